// File: rtl/bill_accumulator.sv
`timescale 1ns/1ps
// bill_accumulator
// Adds item amounts into a running bill, then presents the closed bill to a
// consumer and holds it there until the consumer acknowledges it.
//
// Optional feature: define TAX_EN to add a TAX state. It applies a 12.5 %
// surcharge, floor(total/8), saturating at 16'hFFFF, in the cycle after
// finish, so bill_valid rises two cycles after finish instead of one.
//
// Ports
//   clk          rising-edge system clock
//   rst_n        asynchronous active-low reset
//   start        one-cycle pulse: clear the running bill and open a new one
//   item_valid   item_amount is valid this cycle
//   item_amount  line amount, 12 bits (0..3825)
//   item_ready   high while a bill is open and items are accepted
//   finish       one-cycle pulse: close the open bill
//   bill_ack     consumer has taken the final bill
//   total        running or final bill amount (saturating, 16 bits)
//   item_count   items accepted into the current bill (saturating at 255)
//   bill_valid   total is final; held until bill_ack
//   overflow     sticky: total saturated during this bill
//   busy         high in every state except IDLE
//
// States
//   state    | meaning
//   ST_IDLE  | no open bill; total/item_count keep their last values
//   ST_ACCUM | bill open, items accepted
//   ST_TAX   | one-cycle surcharge step (TAX_EN builds only)
//   ST_DONE  | bill closed, bill_valid high until bill_ack
module bill_accumulator (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        item_valid,
  input  logic [11:0] item_amount,
  output logic        item_ready,
  input  logic        finish,
  input  logic        bill_ack,
  output logic [15:0] total,
  output logic [7:0]  item_count,
  output logic        bill_valid,
  output logic        overflow,
  output logic        busy
);

`ifdef TAX_EN
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_TAX   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd3
  } state_t;
`endif

  state_t      state_q, state_d;
  logic [15:0] total_q, total_d;
  logic [7:0]  count_q, count_d;
  logic        overflow_q, overflow_d;

  // One extra bit of headroom; bit 16 is the saturation trigger.
  logic [16:0] item_sum;
  assign item_sum = {1'b0, total_q} + {5'b0, item_amount};

`ifdef TAX_EN
  logic [16:0] tax_sum;
  assign tax_sum = {1'b0, total_q} + {4'b0, total_q[15:3]};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      total_q    <= 16'd0;
      count_q    <= 8'd0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      total_q    <= total_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    total_d    = total_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    // start wins over everything, including a finish or item in the same cycle.
    if (start) begin
      state_d    = ST_ACCUM;
      total_d    = 16'd0;
      count_d    = 8'd0;
      overflow_d = 1'b0;
    end else begin
      case (state_q)
        ST_ACCUM: begin
          // The item is taken before finish closes the bill.
          if (item_valid) begin
            if (item_sum[16]) begin
              total_d    = 16'hFFFF;
              overflow_d = 1'b1;
            end else begin
              total_d = item_sum[15:0];
            end
            if (count_q != 8'hFF) begin
              count_d = count_q + 8'd1;
            end
          end
          if (finish) begin
`ifdef TAX_EN
            state_d = ST_TAX;
`else
            state_d = ST_DONE;
`endif
          end
        end
`ifdef TAX_EN
        ST_TAX: begin
          if (tax_sum[16]) begin
            total_d    = 16'hFFFF;
            overflow_d = 1'b1;
          end else begin
            total_d = tax_sum[15:0];
          end
          state_d = ST_DONE;
        end
`endif
        ST_DONE: begin
          if (bill_ack) begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  assign item_ready = (state_q == ST_ACCUM);
  assign bill_valid = (state_q == ST_DONE);
  assign busy       = (state_q != ST_IDLE);
  assign total      = total_q;
  assign item_count = count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_bill_accumulator.sv
`timescale 1ns/1ps
module tb_bill_accumulator;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        item_valid;
  logic [11:0] item_amount;
  logic        item_ready;
  logic        finish;
  logic        bill_ack;
  logic [15:0] total;
  logic [7:0]  item_count;
  logic        bill_valid;
  logic        overflow;
  logic        busy;

  int checks = 0;
  int errors = 0;

  bill_accumulator dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .item_valid  (item_valid),
    .item_amount (item_amount),
    .item_ready  (item_ready),
    .finish      (finish),
    .bill_ack    (bill_ack),
    .total       (total),
    .item_count  (item_count),
    .bill_valid  (bill_valid),
    .overflow    (overflow),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: a phase label plus plain integer bill arithmetic.
  localparam int PH_IDLE = 0;
  localparam int PH_OPEN = 1;
  localparam int PH_TAX  = 2;
  localparam int PH_DONE = 3;

  int m_phase;
  int m_total;
  int m_count;
  bit m_ovf;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = PH_IDLE;
      m_total = 0;
      m_count = 0;
      m_ovf   = 1'b0;
    end else if (start) begin
      m_phase = PH_OPEN;
      m_total = 0;
      m_count = 0;
      m_ovf   = 1'b0;
    end else if (m_phase == PH_OPEN) begin
      if (item_valid) begin
        m_total = m_total + int'(item_amount);
        if (m_total > 65535) begin
          m_total = 65535;
          m_ovf   = 1'b1;
        end
        if (m_count < 255) m_count = m_count + 1;
      end
      if (finish) begin
`ifdef TAX_EN
        m_phase = PH_TAX;
`else
        m_phase = PH_DONE;
`endif
      end
    end else if (m_phase == PH_TAX) begin
      m_total = m_total + m_total / 8;
      if (m_total > 65535) begin
        m_total = 65535;
        m_ovf   = 1'b1;
      end
      m_phase = PH_DONE;
    end else if (m_phase == PH_DONE) begin
      if (bill_ack) m_phase = PH_IDLE;
    end
  end

  // Cycle-by-cycle comparison on the falling edge.
  always @(negedge clk) begin
    logic [27:0] dut_v;
    logic [27:0] exp_v;
    if (rst_n) begin
      dut_v = {total, item_count, bill_valid, overflow, item_ready, busy};
      exp_v = {16'(m_total), 8'(m_count), (m_phase == PH_DONE), m_ovf,
               (m_phase == PH_OPEN), (m_phase != PH_IDLE)};
      checks++;
      if (dut_v !== exp_v) begin
        errors++;
        $display("FAIL cycle_model t=%0t got total=%0d cnt=%0d bv=%0b ovf=%0b rdy=%0b busy=%0b expected total=%0d cnt=%0d bv=%0b ovf=%0b rdy=%0b busy=%0b",
                 $time, dut_v[27:12], dut_v[11:4], dut_v[3], dut_v[2], dut_v[1], dut_v[0],
                 exp_v[27:12], exp_v[11:4], exp_v[3], exp_v[2], exp_v[1], exp_v[0]);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then return 1 ns after the rising edge.
  task automatic step(input bit s, input bit iv, input int amt, input bit fin, input bit ack);
    start       = s;
    item_valid  = iv;
    item_amount = 12'(amt);
    finish      = fin;
    bill_ack    = ack;
    @(posedge clk);
    #1;
    start      = 1'b0;
    item_valid = 1'b0;
    item_amount = 12'd0;
    finish     = 1'b0;
    bill_ack   = 1'b0;
  endtask

  task automatic idle(); step(0, 0, 0, 0, 0); endtask

  // Close the bill and advance until bill_valid should be high.
  task automatic close_bill(input bit with_item, input int amt);
    step(0, with_item, amt, 1, 0);
`ifdef TAX_EN
    idle();
`endif
  endtask

  int exp_b1;
  int exp_b3;

  initial begin
    rst_n = 1'b0;
    start = 1'b0; item_valid = 1'b0; item_amount = 12'd0;
    finish = 1'b0; bill_ack = 1'b0;
`ifdef TAX_EN
    exp_b1 = 4696;
    exp_b3 = 675;
`else
    exp_b1 = 4175;
    exp_b3 = 600;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("reset_total", int'(total), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_ready", int'(item_ready), 0);
    rst_n = 1'b1;
    idle();

    // Single bill
    step(1, 0, 0, 0, 0);
    step(0, 1, 100, 0, 0);
    chk("total_latency1", int'(total), 100);
    step(0, 1, 250, 0, 0);
    step(0, 1, 3825, 0, 0);
    close_bill(0, 0);
    chk("b1_valid", int'(bill_valid), 1);
    chk("b1_total", int'(total), exp_b1);
    chk("b1_count", int'(item_count), 3);
    chk("b1_ovf", int'(overflow), 0);

    // Hold in DONE, stray inputs ignored
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 55, 0, 0);
      chk("hold_valid", int'(bill_valid), 1);
      chk("hold_total", int'(total), exp_b1);
    end
    step(0, 0, 0, 0, 1);
    chk("ack_valid_low", int'(bill_valid), 0);
    chk("ack_busy_low", int'(busy), 0);
    step(0, 1, 999, 0, 0);
    step(0, 0, 0, 1, 1);
    chk("idle_item_total", int'(total), exp_b1);
    chk("idle_item_count", int'(item_count), 3);
    chk("idle_finish_ignored", int'(bill_valid), 0);

    // Saturation
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 17; i++) step(0, 1, 3825, 0, 0);
    chk("sat_pre_total", int'(total), 65025);
    chk("sat_pre_ovf", int'(overflow), 0);
    step(0, 1, 3825, 0, 0);
    chk("sat_total", int'(total), 65535);
    chk("sat_ovf", int'(overflow), 1);
    chk("sat_count", int'(item_count), 18);
    step(0, 1, 0, 0, 0);
    chk("sat_sticky_ovf", int'(overflow), 1);
    chk("sat_sticky_total", int'(total), 65535);
    close_bill(0, 0);
    chk("sat_bill_total", int'(total), 65535);
    step(0, 0, 0, 0, 1);

    // Item and finish together
    step(1, 0, 0, 0, 0);
    step(0, 1, 100, 0, 0);
    close_bill(1, 500);
    chk("simul_valid", int'(bill_valid), 1);
    chk("simul_total", int'(total), exp_b3);
    chk("simul_count", int'(item_count), 2);
    // start in DONE takes priority over the held bill
    step(1, 0, 0, 0, 0);
    chk("start_in_done_total", int'(total), 0);
    chk("start_in_done_ready", int'(item_ready), 1);
    step(0, 1, 40, 0, 0);
    // start with finish: start wins
    step(1, 0, 0, 1, 0);
    chk("start_fin_ready", int'(item_ready), 1);
    chk("start_fin_total", int'(total), 0);
    chk("start_fin_valid", int'(bill_valid), 0);
    idle();
    chk("start_fin_valid_later", int'(bill_valid), 0);

    // Reset mid-bill
    step(0, 1, 11, 0, 0);
    step(0, 1, 22, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_total", int'(total), 0);
    chk("async_count", int'(item_count), 0);
    chk("async_busy", int'(busy), 0);
    chk("async_ready", int'(item_ready), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(0, 1, 33, 1, 0);
    chk("post_reset_idle_total", int'(total), 0);
    step(1, 0, 0, 0, 0);
    step(0, 1, 7, 0, 0);
    close_bill(0, 0);
    chk("post_reset_total", int'(total), 7);
    chk("post_reset_count", int'(item_count), 1);
    chk("post_reset_valid", int'(bill_valid), 1);
    step(0, 0, 0, 0, 1);

    // Count saturation
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 300; i++) step(0, 1, 0, 0, 0);
    chk("cnt_sat_count", int'(item_count), 255);
    chk("cnt_sat_total", int'(total), 0);
    chk("cnt_sat_ovf", int'(overflow), 0);
    close_bill(0, 0);
    step(0, 0, 0, 0, 1);

    // Empty bill
    step(1, 0, 0, 0, 0);
    close_bill(0, 0);
    chk("empty_valid", int'(bill_valid), 1);
    chk("empty_total", int'(total), 0);
    chk("empty_count", int'(item_count), 0);
    step(0, 0, 0, 0, 1);
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bill_accumulator.md
BILL_ACCUMULATOR -- requirements
Module: bill_accumulator

Interface
REQ-001 Clock/reset SHALL be fixed: one clock, `clk`; reset `rst_n`, asynchronous assert, active-low.
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  one-cycle pulse: clear running bill and open a new one.
REQ-005 item_valid  input  1  item_amount is valid this cycle.
REQ-006 item_amount  input  12  line amount (price x qty) from the 8x4 multiplier stage, range 0..3825.
REQ-007 item_ready  output  1  block accepts an item this cycle.
REQ-008 finish  input  1  one-cycle pulse: close the bill.
REQ-009 bill_ack  input  1  consumer has taken the final bill.
REQ-010 total  output  16  running or final bill amount.
REQ-011 item_count  output  8  number of items accepted into the current bill.
REQ-012 bill_valid  output  1  total is final; held until bill_ack.
REQ-013 overflow  output  1  sticky: total saturated during this bill.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 FSM states SHALL be IDLE, ACCUM, TAX (only with TAX_EN), DONE.
REQ-016 IDLE: item_ready=0, bill_valid=0; total and item_count hold their last values.
REQ-017 start SHALL take priority in every state: next state ACCUM; total, item_count and overflow cleared at that edge.
REQ-018 ACCUM: item_ready=1; on item_valid&&item_ready, at that clock edge total <= total+item_amount (visible next cycle, latency 1).
REQ-019 Addition SHALL be computed 17-bit; a carry sets total=16'hFFFF and overflow=1; total stays saturated for subsequent items.
REQ-020 item_count SHALL increment per accepted item, saturating at 255 with no wrap.
REQ-021 item_valid in IDLE, TAX or DONE SHALL be ignored: no count change, no total change.
REQ-022 finish in ACCUM SHALL move to DONE (or TAX with TAX_EN); finish in any other state SHALL be ignored.
REQ-023 If item_valid and finish occur in the same ACCUM cycle, the item SHALL be accumulated first and then the bill closed.
REQ-024 If start and finish occur in the same cycle, start SHALL win and finish is dropped.
REQ-025 DONE: bill_valid=1, total and item_count stable; on bill_ack go to IDLE, with bill_valid low next cycle.
REQ-026 bill_ack outside DONE SHALL be ignored.
REQ-027 finish with zero items SHALL produce bill_valid with total=0 and item_count=0.

Reset
REQ-028 While rst_n=0: state IDLE, total=0, item_count=0, overflow=0, bill_valid=0, item_ready=0, busy=0.
REQ-029 Reset mid-bill (any state) SHALL discard the bill with no bill_valid pulse; operation resumes only on the next start.

Configuration
REQ-030 The macro TAX_EN, when defined, SHALL add state TAX: one cycle after finish, total <= total + (total>>3) (12.5%, floor), saturating at 16'hFFFF with overflow set; then DONE, so bill_valid asserts 2 cycles after finish.
REQ-031 Without TAX_EN, the TAX state and adder SHALL not exist, and bill_valid SHALL assert 1 cycle after finish.

Verification
REQ-032 Single bill: reset, start, items 100, 250, 3825, finish -> bill_valid, total=4175, item_count=3, overflow=0; with TAX_EN total=4696.
REQ-033 Saturation: start, 18 items of 3825 -> total=65535 after the 18th item, overflow=1 sticky, item_count=18.
REQ-034 Simultaneity: item 500 with finish in the same cycle -> total includes 500; start with finish in the same cycle -> ACCUM, total=0, no bill_valid.
REQ-035 Handshake: hold bill_ack=0 for 10 cycles in DONE -> bill_valid and total stable throughout; bill_ack=1 -> IDLE, bill_valid=0 next cycle; item_valid in IDLE -> ignored.
REQ-036 Reset mid-bill: after 2 items, pulse rst_n low asynchronously -> all outputs zero immediately; then start, item 7, finish -> total=7, item_count=1.
REQ-037 Count saturation: 300 items of amount 0 -> item_count=255, total=0, overflow=0.
